// File: rtl/dm_pkg.sv
// Shared defaults, FSM encoding and helpers for the data-memory arbiter.
package dm_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 8;
  localparam int MEM_LAT_DEF   = 1;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Core-side request bus plus memory-side port of the arbiter, bundled as one interface.
interface dm_arbiter_if
  import dm_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        wren;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;
    logic [ADDR_W-1:0]           mem_address;
    logic [DATA_W-1:0]           mem_data;
    logic                        mem_wren;
    logic [DATA_W-1:0]           mem_q;
    logic                        busy;

    modport slave (
        input  req, wren, addr, wdata, mem_q,
        output gnt, rvalid, rdata, mem_address, mem_data, mem_wren, busy
    );

    modport master (
        output req, wren, addr, wdata, mem_q,
        input  gnt, rvalid, rdata, mem_address, mem_data, mem_wren, busy
    );
endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Round-robin winner selection: first requester after last_winner, wrapping around.
module rr_pick
  import dm_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     last_winner_i,
    output logic [NUM_CORES-1:0] winner_o,
    output logic [IDX_W-1:0]     winner_idx_o
);
    logic             found;
    logic [IDX_W-1:0] cand_idx;

    // NOTE: every output and temporary gets a default first so no path infers a latch.
    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        found        = 1'b0;
        cand_idx     = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand_idx = IDX_W'((int'(last_winner_i) + k) % NUM_CORES);
            if (!found && req_i[cand_idx]) begin
                found              = 1'b1;
                winner_o[cand_idx] = 1'b1;
                winner_idx_o       = cand_idx;
            end
        end
    end
endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter granting NUM_CORES cores access to one single-port data memory.
module dm_arbiter
  import dm_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_LAT   = MEM_LAT_DEF
) (
    input logic         clock,
    input logic         rst_n,
    dm_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_CORES);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d, idx_q, idx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic                 wren_q, wren_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;

    logic [NUM_CORES-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
        assign addr_arr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = bus.wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_pick (
        .req_i         (bus.req),
        .last_winner_i (last_q),
        .winner_o      (pick_onehot),
        .winner_idx_o  (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wren_d   = wren_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    wren_d  = bus.wren[pick_idx];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wren_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT);
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                // Address stays on mem_address until the counter drains, then mem_q is valid.
                if (cnt_q == '0) begin
                    rvalid_d[idx_q] = 1'b1;
                    rdata_d         = bus.mem_q;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the whole datapath is reset, not just control, because mem_address, mem_data and rdata must read 0 while rst_n is low.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDX_W'(NUM_CORES - 1);
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wren_q   <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wren_q   <= wren_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_data    = wdata_q;
    assign bus.mem_wren    = (state_q == ACCESS) && wren_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: transaction table plus round-robin, reset and dropped-request sequences.
module tb_dm_arbiter;
    import dm_pkg::*;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic rst_n;

    dm_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM, one cycle read latency.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clock) begin
        if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_address];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_core(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[c]             = 1'b1;
        bus.wren[c]            = wr;
        bus.addr[c*AW +: AW]   = a;
        bus.wdata[c*DW +: DW]  = d;
    endtask

    task automatic clear_inputs();
        bus.req   = '0;
        bus.wren  = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(output logic [NC-1:0] g, input int budget);
        g = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            check("gnt/rvalid same cycle", {31'd0, (bus.gnt != 0) && (bus.rvalid != 0)}, 32'd0);
            if (bus.gnt != 0) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (!bus.busy) break;
        end
        check(name, {31'd0, bus.busy}, 32'd0);
    endtask

    typedef struct {
        int            core;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input int i, input vec_t v);
        set_core(v.core, v.wr, v.addr, v.wdata);
        @(negedge clock);
        check($sformatf("v%0d gnt", i), {28'd0, bus.gnt}, 32'd1 << v.core);
        check($sformatf("v%0d mem_wren", i), {31'd0, bus.mem_wren}, {31'd0, v.wr});
        check($sformatf("v%0d mem_address", i), {16'd0, bus.mem_address}, {16'd0, v.addr});
        if (v.wr) check($sformatf("v%0d mem_data", i), {24'd0, bus.mem_data}, {24'd0, v.wdata});
        bus.req[v.core] = 1'b0;
        if (v.wr) begin
            @(negedge clock);
            check($sformatf("v%0d busy after write", i), {31'd0, bus.busy}, 32'd0);
            check($sformatf("v%0d wren after write", i), {31'd0, bus.mem_wren}, 32'd0);
        end else begin
            repeat (2) begin
                @(negedge clock);
                check($sformatf("v%0d early rvalid", i), {28'd0, bus.rvalid}, 32'd0);
                check($sformatf("v%0d rd mem_wren", i), {31'd0, bus.mem_wren}, 32'd0);
            end
            @(negedge clock);
            check($sformatf("v%0d rvalid", i), {28'd0, bus.rvalid}, 32'd1 << v.core);
            check($sformatf("v%0d rdata", i), {24'd0, bus.rdata}, {24'd0, v.exp_rdata});
            check($sformatf("v%0d busy after read", i), {31'd0, bus.busy}, 32'd0);
            @(negedge clock);
            check($sformatf("v%0d rvalid one cycle", i), {28'd0, bus.rvalid}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [NC-1:0] got;
        int            exp_core;
        int            since3;
        int            max3;

        vecs[0] = '{2, 1'b1, 16'h0010, 8'hA5, 8'h00};
        vecs[1] = '{1, 1'b0, 16'h0010, 8'h00, 8'hA5};
        vecs[2] = '{0, 1'b1, 16'h1234, 8'h3C, 8'h00};
        vecs[3] = '{3, 1'b1, 16'hFFFF, 8'h5A, 8'h00};
        vecs[4] = '{3, 1'b0, 16'h1234, 8'h00, 8'h3C};
        vecs[5] = '{0, 1'b0, 16'hFFFF, 8'h00, 8'h5A};
        vecs[6] = '{1, 1'b1, 16'h0000, 8'hFF, 8'h00};
        vecs[7] = '{2, 1'b0, 16'h0000, 8'h00, 8'hFF};

        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        check("rst gnt", {28'd0, bus.gnt}, 32'd0);
        check("rst rvalid", {28'd0, bus.rvalid}, 32'd0);
        check("rst rdata", {24'd0, bus.rdata}, 32'd0);
        check("rst mem_address", {16'd0, bus.mem_address}, 32'd0);
        check("rst mem_data", {24'd0, bus.mem_data}, 32'd0);
        check("rst mem_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // All cores request continuously: strict 0,1,2,3 rotation with reads and writes mixed.
        do_reset();
        for (int c = 0; c < NC; c++) set_core(c, (c % 2) == 0, AW'(16'h0100 + c), DW'(8'h10 + c));
        exp_core = 0;
        since3   = 0;
        max3     = 0;
        for (int g = 0; g < 8; g++) begin
            wait_gnt(got, 12);
            check($sformatf("rr grant %0d", g), {28'd0, got}, 32'd1 << exp_core);
            if (got == 4'b1000) since3 = 0;
            else since3++;
            if (since3 > max3) max3 = since3;
            exp_core = (exp_core + 1) % NC;
        end
        check("rr core3 max grants between", max3, 3);
        clear_inputs();
        wait_idle("rr drain", 10);

        // Reset during the ACCESS cycle of core 0's write.
        set_core(0, 1'b1, 16'h0200, 8'h77);
        @(negedge clock);
        check("rst-mid gnt", {28'd0, bus.gnt}, 32'd1);
        check("rst-mid wren before", {31'd0, bus.mem_wren}, 32'd1);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check("rst-mid wren dropped", {31'd0, bus.mem_wren}, 32'd0);
        check("rst-mid busy", {31'd0, bus.busy}, 32'd0);
        check("rst-mid gnt cleared", {28'd0, bus.gnt}, 32'd0);
        check("rst-mid mem_address", {16'd0, bus.mem_address}, 32'd0);
        check("rst-mid mem_data", {24'd0, bus.mem_data}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        set_core(0, 1'b1, 16'h0300, 8'h11);
        set_core(1, 1'b1, 16'h0301, 8'h22);
        @(negedge clock);
        check("post-rst first gnt", {28'd0, bus.gnt}, 32'd1);
        clear_inputs();
        repeat (3) begin
            @(negedge clock);
            check("post-rst no rvalid", {28'd0, bus.rvalid}, 32'd0);
        end

        // Core 0 requests only while core 1's read is in flight, then withdraws.
        set_core(1, 1'b0, 16'h0010, 8'h00);
        @(negedge clock);
        check("drop gnt core1", {28'd0, bus.gnt}, 32'd2);
        bus.req[1] = 1'b0;
        set_core(0, 1'b1, 16'h0400, 8'h99);
        @(negedge clock);
        check("drop rdwait busy", {31'd0, bus.busy}, 32'd1);
        bus.req[0] = 1'b0;
        @(negedge clock);
        check("drop c3 gnt", {28'd0, bus.gnt}, 32'd0);
        @(negedge clock);
        check("drop rvalid core1", {28'd0, bus.rvalid}, 32'd2);
        check("drop rdata", {24'd0, bus.rdata}, 32'h0000_00A5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("drop no gnt %0d", k), {28'd0, bus.gnt}, 32'd0);
            check($sformatf("drop no wren %0d", k), {31'd0, bus.mem_wren}, 32'd0);
            check($sformatf("drop idle %0d", k), {31'd0, bus.busy}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, number of requesting cores.
REQ-002 Parameter ADDR_W, default 16, data-memory address width.
REQ-003 Parameter DATA_W, default 8, data-memory word width.
REQ-004 Parameter MEM_LAT, default 1, memory read latency in clock cycles (range 1..7).
REQ-005 clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_CORES  per-core access request; bit i belongs to core i.
REQ-008 wren  in  NUM_CORES  per-core access type, 1 = write, 0 = read.
REQ-009 addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 wdata  in  NUM_CORES*DATA_W  per-core write data; same slicing as addr.
REQ-011 gnt  out  NUM_CORES  one-hot acceptance pulse, one cycle long.
REQ-012 rvalid  out  NUM_CORES  one-hot read-data-valid pulse, one cycle long.
REQ-013 rdata  out  DATA_W  read data, shared by all cores, meaningful only while rvalid is non-zero.
REQ-014 mem_address  out  ADDR_W  address to the single-port data memory.
REQ-015 mem_data  out  DATA_W  write data to the memory.
REQ-016 mem_wren  out  1  memory write enable.
REQ-017 mem_q  in  DATA_W  memory read data, valid MEM_LAT cycles after the address is presented.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCESS and RDWAIT.
REQ-020 In IDLE with req != 0, the arbiter SHALL select the first requesting core in round-robin order, starting at (last_winner+1) mod NUM_CORES.
REQ-021 On that edge it SHALL latch the winner's index, addr, wdata and wren, pulse gnt[winner] for the following cycle, and enter ACCESS.
REQ-022 In ACCESS, mem_address and mem_data SHALL equal the latched values and mem_wren SHALL equal the latched wren.
REQ-023 A write SHALL go ACCESS -> IDLE, so each write costs 2 cycles.
REQ-024 A read SHALL go ACCESS -> RDWAIT, hold mem_address for MEM_LAT cycles using a 3-bit down-counter, then pulse rvalid[winner] with rdata = mem_q and return to IDLE.
REQ-025 mem_wren SHALL be 0 in every state except ACCESS with a latched write.
REQ-026 last_winner SHALL update only when a grant is issued.
REQ-027 The arbiter SHALL ignore req while it is not in IDLE; a requester SHALL hold req, wren, addr and wdata stable until it sees its gnt.
REQ-028 If a req bit drops before it is granted, no access SHALL occur for that core.
REQ-029 A core that keeps req high after gnt SHALL be treated as a new request at the next IDLE cycle, subject to round-robin order.
REQ-030 With req = all ones held continuously, the grant order SHALL be 0,1,2,3,0,... with no core skipped, so the wait for any core is bounded at NUM_CORES accesses.
REQ-031 gnt and rvalid SHALL each be one-hot or zero, and never non-zero in the same cycle for different cores.

Reset
REQ-032 While rst_n = 0, asynchronously: state = IDLE, last_winner = NUM_CORES-1 (so core 0 has first priority), and counter = 0.
REQ-033 While rst_n = 0, asynchronously: gnt = 0, rvalid = 0, rdata = 0, mem_address = 0, mem_data = 0, mem_wren = 0, busy = 0.
REQ-034 Reset asserted mid-access SHALL drop mem_wren within the same cycle and abandon any pending rvalid.

Structure
REQ-035 NUM_CORES, ADDR_W, DATA_W, MEM_LAT defaults and the state encoding SHALL live in the shared package dm_pkg.
REQ-036 Winner selection SHALL be a sub-module rr_pick with inputs req and last_winner and outputs a one-hot winner plus its index, purely combinational.
REQ-037 The arbiter SHALL sit between the four processor cores and the data memory, replacing the direct connection from core 0.

Verification
REQ-038 Reset release, core 2 writes 0xA5 to 0x0010 -> gnt[2] 1 cycle after req; next cycle mem_wren = 1, mem_address = 0x0010, mem_data = 0xA5; busy low 2 cycles after req.
REQ-039 Core 1 reads 0x0010 with MEM_LAT = 1 after the write above -> rvalid[1] = 1 and rdata = 0xA5, exactly 3 cycles after gnt[1].
REQ-040 All four cores request at once after reset -> grants in order 0,1,2,3; each gnt is one-hot.
REQ-041 Core 3 keeps req high while cores 0-2 keep requesting -> core 3 never waits more than 4 grants.
REQ-042 rst_n pulled low during the ACCESS of a write -> mem_wren = 0 immediately; no rvalid; the first grant after reset goes to core 0.
REQ-043 Core 0 raises req, then drops it while a read for core 1 is in RDWAIT -> no gnt[0] and no memory access for core 0.
